uart_rx_ctrl_param: RTL and testbench

- Parametrised next-generation UART receive controller.
- Combines the frame state machine with the oversampling edge counter and bit counter that were previously separate.
- Drives the sampler, deserializer, start/parity/stop checker enables and the frame-complete strobe.
- Supports runtime prescale, data width, parity and one or two stop bits. Supports back-to-back frames and error reporting.
- Sits between the RX pin synchroniser / data sampler and the deserializer inside UART_RX.

---
 rtl/uart_rx_pkg.sv | 37 +++
 rtl/uart_rx_edge_bit_cnt.sv | 67 ++++++
 rtl/uart_rx_ctrl_param.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl_param.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller:
//   - rx_state_e    : frame state machine encoding
//   - PRESCALE_*    : legal oversampling ratios and the fallback ratio
//   - chk_offset()  : oversample edge index at which a bit is checked (P/2+1)
//   - is_legal_prescale() : true for the supported oversampling ratios
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        OUTPUT = 3'd5,
        BREAK  = 3'd6
    } rx_state_e;

    localparam int unsigned PRESCALE_8       = 8;
    localparam int unsigned PRESCALE_16      = 16;
    localparam int unsigned PRESCALE_32      = 32;
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_16;

    localparam int unsigned MIN_DATA_LEN = 5;

    // Sample a little past mid-bit so the majority voter has seen its window.
    function automatic int unsigned chk_offset(input int unsigned p);
        return (p >> 1) + 1;
    endfunction

    function automatic logic is_legal_prescale(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversample edge counter and bit counter for the UART receive controller.
// The edge counter runs 0..edge_max; on edge_max it wraps and the bit counter
// advances. Clear has priority over enable.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   cnt_en     : advance the edge counter this cycle
//   cnt_clr    : force both counters to zero next cycle
//   edge_max   : last edge index of a bit (prescale - 1)
//   edge_cnt   : current edge index within the bit
//   bit_cnt    : current bit index within the frame
//   edge_last  : edge_cnt is at edge_max (bit ends this cycle)
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic [PRESCALE_W-1:0] edge_max,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  edge_last
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;

    assign edge_last = (edge_cnt_q == edge_max);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps always_comb from inferring a latch.
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (cnt_clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (cnt_en) begin
            if (edge_last) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl_param.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_param
// UART receive controller: frame FSM plus oversample edge/bit counters. Drives
// the sampler, deserializer and start/parity/stop checker strobes and reports
// frame completion and errors as registered one-cycle pulses.
//
// Optional feature macro: UART_RX_BREAK_DET_EN
//   defined   : adds brk_det output and BREAK state (all-zero frame with a stop
//               failure is reported as a break and held until the line idles)
//   undefined : a break is reported as frm_err
//
// Ports:
//   clk, rst          : oversampling clock, asynchronous active-low reset
//   RX_IN             : synchronised serial line
//   prescale          : oversampling ratio (8/16/32; others treated as 16)
//   data_len          : data bits per frame (clamped into 5..DATA_WIDTH)
//   PAR_EN, STP2_EN   : parity bit present, two stop bits
//   sampled_bit       : majority-voted bit from the sampler
//   strt_glitch, par_err, stp_err : checker results, valid on their strobe
//   edge_cnt, bit_cnt : oversample edge index, bit index (start = 0)
//   dat_samp_en       : sampler enable
//   deser_en          : deserializer shift strobe
//   strt_chk_en, par_chk_en, stp_chk_en : checker strobes
//   data_valid, frm_err, par_err_flag   : registered one-cycle result pulses
//   brk_det           : registered one-cycle break pulse (feature only)
// -----------------------------------------------------------------------------
module uart_rx_ctrl_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RX_IN,
    input  logic [PRESCALE_W-1:0]             prescale,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]   data_len,
    input  logic                              PAR_EN,
    input  logic                              STP2_EN,
    input  logic                              sampled_bit,
    input  logic                              strt_glitch,
    input  logic                              par_err,
    input  logic                              stp_err,
    output logic [PRESCALE_W-1:0]             edge_cnt,
    output logic [BIT_CNT_W-1:0]              bit_cnt,
    output logic                              dat_samp_en,
    output logic                              deser_en,
    output logic                              strt_chk_en,
    output logic                              par_chk_en,
    output logic                              stp_chk_en,
    output logic                              data_valid,
    output logic                              frm_err,
    output logic                              par_err_flag
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                              brk_det
`endif
);

    localparam int LEN_W = $clog2(DATA_WIDTH + 1);

    rx_state_e state_q, state_d;

    // Frame configuration, frozen for the duration of a frame.
    logic [PRESCALE_W-1:0] prescale_q, prescale_d, prescale_legal;
    logic [LEN_W-1:0]      len_q, len_d, len_clamped;
    logic                  par_en_q, par_en_d;
    logic                  stp2_en_q, stp2_en_d;

    logic data_valid_q, data_valid_d;
    logic frm_err_q, frm_err_d;
    logic par_err_flag_q, par_err_flag_d;

    logic                  frame_start;
    logic                  chk_strobe;
    logic                  bit_end;
    logic                  cnt_en, cnt_clr;
    logic [PRESCALE_W-1:0] strobe_pt;
    logic [BIT_CNT_W-1:0]  last_data_bit, last_stop_bit;

`ifdef UART_RX_BREAK_DET_EN
    logic brk_det_q, brk_det_d;
    logic seen_one_q, seen_one_d;
`else
    // The sampled value only matters for break detection.
    logic unused_sampled_bit;
    assign unused_sampled_bit = sampled_bit;
`endif

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    assign cnt_en  = (state_q != IDLE) && (state_q != OUTPUT);
    assign cnt_clr = (state_d == IDLE) || (state_d == OUTPUT);

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_cnt (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .edge_max  (prescale_q - PRESCALE_W'(1)),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .edge_last (bit_end)
    );

    assign strobe_pt  = PRESCALE_W'(chk_offset(32'(prescale_q)));
    assign chk_strobe = (edge_cnt == strobe_pt);

    // Frame layout: start = 0, data = 1..L, optional parity, then stop bit(s).
    assign last_data_bit = BIT_CNT_W'(len_q);
    assign last_stop_bit = last_data_bit + BIT_CNT_W'(1)
                         + BIT_CNT_W'(par_en_q) + BIT_CNT_W'(stp2_en_q);

    // ------------------------------------------------------------------
    // Configuration latch (on every entry to START, including back-to-back)
    // ------------------------------------------------------------------
    assign frame_start = (state_d == START) && (state_q != START);

    always_comb begin
        prescale_legal = is_legal_prescale(32'(prescale)) ? prescale
                                                          : PRESCALE_W'(PRESCALE_DEFAULT);
        if (data_len < LEN_W'(MIN_DATA_LEN)) begin
            len_clamped = LEN_W'(MIN_DATA_LEN);
        end else if (data_len > LEN_W'(DATA_WIDTH)) begin
            len_clamped = LEN_W'(DATA_WIDTH);
        end else begin
            len_clamped = data_len;
        end
    end

    always_comb begin
        prescale_d = prescale_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        stp2_en_d  = stp2_en_q;
        if (frame_start) begin
            prescale_d = prescale_legal;
            len_d      = len_clamped;
            par_en_d   = PAR_EN;
            stp2_en_d  = STP2_EN;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        dat_samp_en    = 1'b0;
        deser_en       = 1'b0;
        strt_chk_en    = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;
        data_valid_d   = 1'b0;
        frm_err_d      = 1'b0;
        par_err_flag_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_det_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!RX_IN) state_d = START;
            end

            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = chk_strobe;
                // A start glitch is dropped silently.
                if (chk_strobe && strt_glitch) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = chk_strobe;
                if (bit_end && (bit_cnt == last_data_bit)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end

            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = chk_strobe;
                if (chk_strobe && par_err) begin
                    state_d        = IDLE;
                    par_err_flag_d = 1'b1;
                end else if (bit_end) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = chk_strobe;
                if (chk_strobe && stp_err) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (!(seen_one_q || sampled_bit)) begin
                        state_d   = BREAK;
                        brk_det_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        frm_err_d = 1'b1;
                    end
`else
                    state_d   = IDLE;
                    frm_err_d = 1'b1;
`endif
                end else if (chk_strobe && (bit_cnt == last_stop_bit)) begin
                    // Leave mid-stop-bit so a following start edge is not missed.
                    state_d = OUTPUT;
                end
            end

            OUTPUT: begin
                data_valid_d = 1'b1;
                state_d      = RX_IN ? IDLE : START;
            end

`ifdef UART_RX_BREAK_DET_EN
            BREAK: begin
                if (chk_strobe && RX_IN) state_d = IDLE;
            end
`endif

            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_BREAK_DET_EN
    // Remembers whether any checked bit of the current frame was a 1.
    always_comb begin
        seen_one_d = seen_one_q;
        if (frame_start) begin
            seen_one_d = 1'b0;
        end else if (chk_strobe && sampled_bit && dat_samp_en) begin
            seen_one_d = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            prescale_q     <= PRESCALE_W'(PRESCALE_DEFAULT);
            len_q          <= LEN_W'(DATA_WIDTH);
            par_en_q       <= 1'b0;
            stp2_en_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            frm_err_q      <= 1'b0;
            par_err_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prescale_q     <= prescale_d;
            len_q          <= len_d;
            par_en_q       <= par_en_d;
            stp2_en_q      <= stp2_en_d;
            data_valid_q   <= data_valid_d;
            frm_err_q      <= frm_err_d;
            par_err_flag_q <= par_err_flag_d;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_det_q  <= 1'b0;
            seen_one_q <= 1'b0;
        end else begin
            brk_det_q  <= brk_det_d;
            seen_one_q <= seen_one_d;
        end
    end

    assign brk_det = brk_det_q;
`endif

    assign data_valid   = data_valid_q;
    assign frm_err      = frm_err_q;
    assign par_err_flag = par_err_flag_q;

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl_param
// Directed bench for uart_rx_ctrl_param. Frames are driven bit-by-bit on RX_IN;
// the upstream sampler/checkers are modelled from the line itself. Expected
// result pulses are queued as frames are sent and compared as the DUT emits
// them; data is rebuilt from the deserializer strobes.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl_param;

    localparam int EV_NONE  = 0;
    localparam int EV_VALID = 1;
    localparam int EV_FRM   = 2;
    localparam int EV_PAR   = 3;
    localparam int EV_BRK   = 4;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          nbits;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic [3:0] data_len;
    logic       par_en;
    logic       stp2_en;
    logic       par_force;
    logic       sampled_bit, strt_glitch, par_err, stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frm_err, par_err_flag;
    logic       brk_obs;

    int   checks = 0;
    int   errors = 0;
    int   exp_strobe = 5;
    ev_t  sb[$];

    // Upstream models: sampler follows the line, start is bad if the line is
    // high, stop is bad if the line is low, parity error is forced by the bench.
    assign sampled_bit = rx_in;
    assign strt_glitch = rx_in;
    assign stp_err     = ~rx_in;
    assign par_err     = par_force;

`ifdef UART_RX_BREAK_DET_EN
    logic brk_det;
    assign brk_obs = brk_det;
`else
    assign brk_obs = 1'b0;
`endif

    uart_rx_ctrl_param #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6),
        .BIT_CNT_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (rx_in),
        .prescale     (prescale),
        .data_len     (data_len),
        .PAR_EN       (par_en),
        .STP2_EN      (stp2_en),
        .sampled_bit  (sampled_bit),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .dat_samp_en  (dat_samp_en),
        .deser_en     (deser_en),
        .strt_chk_en  (strt_chk_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .data_valid   (data_valid),
        .frm_err      (frm_err),
        .par_err_flag (par_err_flag)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .brk_det      (brk_det)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_edge"}, 32'(edge_cnt), 0);
        check({tag, "_bit"}, 32'(bit_cnt), 0);
        check({tag, "_strobes"},
              {22'd0, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, frm_err, par_err_flag, brk_obs, 1'b0}, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        rx_in = v;
        idle(n);
    endtask

    // Drives one frame; called and returns at posedge+1. abort_bit >= 0
    // asserts reset two cycles into that bit and returns with reset held.
    task automatic send_frame(input int p_cfg, input int p_drv, input int l_cfg, input int l_drv,
                              input bit par, input bit stp2, input logic [31:0] data,
                              input bit force_perr, input bit short_stop, input bit scramble,
                              input int abort_bit);
        logic [15:0] bits;
        int nbits;
        int len;
        prescale   = 6'(p_cfg);
        data_len   = 4'(l_cfg);
        par_en     = par;
        stp2_en    = stp2;
        exp_strobe = p_drv / 2 + 1;
        bits       = '0;
        bits[0]    = 1'b0;
        for (int i = 0; i < l_drv; i++) bits[1+i] = data[i];
        nbits = 1 + l_drv;
        if (par) begin
            bits[nbits] = ^(data & ((32'd1 << l_drv) - 1));
            nbits++;
        end
        bits[nbits] = 1'b1;
        nbits++;
        if (stp2) begin
            bits[nbits] = 1'b1;
            nbits++;
        end
        for (int b = 0; b < nbits; b++) begin
            len = (short_stop && b == nbits - 1) ? p_drv / 2 + 3 : p_drv;
            if (b == 1 && scramble) begin
                prescale = 6'd8;
                data_len = 4'd5;
                par_en   = ~par;
                stp2_en  = ~stp2;
            end
            par_force = force_perr && par && (b == l_drv + 1);
            for (int c = 0; c < len; c++) begin
                rx_in = bits[b];
                if (b == abort_bit && c == 2) begin
                    #2 rst = 1'b0;
                    #1 check_all_zero("reset_mid_frame");
                    par_force = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        par_force = 1'b0;
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] data, input int nbits);
        ev_t e;
        e.kind  = kind;
        e.data  = data;
        e.nbits = nbits;
        sb.push_back(e);
    endtask

    // Output monitor: rebuilds data from deser_en and scores result pulses.
    initial begin : monitor
        int          nb;
        int          npulse;
        int          kind_obs;
        logic [31:0] acc;
        ev_t         e;
        nb  = 0;
        acc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (strt_chk_en) begin
                    nb  = 0;
                    acc = '0;
                end
                if (deser_en) begin
                    check("deser_edge", 32'(edge_cnt), exp_strobe);
                    check("deser_bit_idx", 32'(bit_cnt), nb + 1);
                    if (nb < 32) acc[nb] = sampled_bit;
                    nb++;
                end
                npulse = int'(data_valid) + int'(frm_err) + int'(par_err_flag) + int'(brk_obs);
                if (npulse != 0) begin
                    check("pulse_onehot", npulse, 1);
                    kind_obs = data_valid ? EV_VALID : frm_err ? EV_FRM :
                               par_err_flag ? EV_PAR : EV_BRK;
                    if (sb.size() == 0) begin
                        check("unexpected_event", kind_obs, EV_NONE);
                    end else begin
                        e = sb.pop_front();
                        check("event_kind", kind_obs, e.kind);
                        if (e.kind == EV_VALID) begin
                            check("rx_data", acc, e.data);
                            check("rx_nbits", nb, e.nbits);
                        end
                        if (e.kind == EV_FRM || e.kind == EV_PAR) begin
                            check("idle_after_err_samp", 32'(dat_samp_en), 0);
                            check("idle_after_err_edge", 32'(edge_cnt), 0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        rx_in     = 1'b1;
        prescale  = 6'd8;
        data_len  = 4'd8;
        par_en    = 1'b0;
        stp2_en   = 1'b0;
        par_force = 1'b0;

        // Reset state
        idle(3);
        check_all_zero("reset");
        rst = 1'b1;
        idle(3);
        check_all_zero("after_release");

        // P=8, L=8, no parity, one stop, 0xA5
        expect_ev(EV_VALID, 32'hA5, 8);
        send_frame(8, 8, 8, 8, 1'b0, 1'b0, 32'hA5, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        check("p8_pending", sb.size(), 0);

        // P=16, L=7, parity with forced parity error
        expect_ev(EV_PAR, 32'h0, 0);
        send_frame(16, 16, 7, 7, 1'b1, 1'b0, 32'h13, 1'b1, 1'b0, 1'b0, -1);
        idle(20);
        check("par_pending", sb.size(), 0);

        // Start glitch: line low for 3 clocks only
        prescale = 6'd16;
        data_len = 4'd8;
        par_en   = 1'b0;
        stp2_en  = 1'b0;
        drive_level(1'b0, 3);
        drive_level(1'b1, 40);
        check("glitch_pending", sb.size(), 0);
        check("glitch_idle_samp", 32'(dat_samp_en), 0);
        check("glitch_idle_edge", 32'(edge_cnt), 0);

        // Back-to-back, two stop bits; first frame's inputs change mid-frame
        expect_ev(EV_VALID, 32'h3C, 8);
        expect_ev(EV_VALID, 32'hC3, 8);
        send_frame(16, 16, 8, 8, 1'b0, 1'b1, 32'h3C, 1'b0, 1'b1, 1'b1, -1);
        send_frame(16, 16, 8, 8, 1'b0, 1'b1, 32'hC3, 1'b0, 1'b0, 1'b0, -1);
        idle(40);
        check("b2b_pending", sb.size(), 0);

        // Illegal prescale -> 16, short data_len -> 5; long data_len -> 8 at P=32
        expect_ev(EV_VALID, 32'h15, 5);
        send_frame(20, 16, 3, 5, 1'b0, 1'b0, 32'h15, 1'b0, 1'b0, 1'b0, -1);
        expect_ev(EV_VALID, 32'h5A, 8);
        send_frame(32, 32, 15, 8, 1'b0, 1'b0, 32'h5A, 1'b0, 1'b0, 1'b0, -1);
        idle(40);
        check("clamp_pending", sb.size(), 0);

        // Break: line low for 12 bit times at P=8
        prescale   = 6'd8;
        data_len   = 4'd8;
        par_en     = 1'b0;
        stp2_en    = 1'b0;
        exp_strobe = 5;
`ifdef UART_RX_BREAK_DET_EN
        expect_ev(EV_BRK, 32'h0, 0);
`else
        expect_ev(EV_FRM, 32'h0, 0);
        // The line is still low after the error, so a new frame starts and
        // completes once the line returns high.
        expect_ev(EV_VALID, 32'hFE, 8);
`endif
        drive_level(1'b0, 90);
`ifdef UART_RX_BREAK_DET_EN
        check("break_hold_samp", 32'(dat_samp_en), 0);
        check("break_hold_edge", 32'(edge_cnt), 1);
`else
        check("break_restart_samp", 32'(dat_samp_en), 1);
        check("break_restart_edge", 32'(edge_cnt), 2);
`endif
        drive_level(1'b0, 6);
        drive_level(1'b1, 100);
        check("break_pending", sb.size(), 0);
        check("break_end_samp", 32'(dat_samp_en), 0);
        check("break_end_edge", 32'(edge_cnt), 0);

        // Reset at bit 4 of a frame, then a clean frame
        send_frame(16, 16, 8, 8, 1'b0, 1'b0, 32'h69, 1'b0, 1'b0, 1'b0, 4);
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        idle(5);
        check_all_zero("reset_held");
        rst = 1'b1;
        idle(5);
        expect_ev(EV_VALID, 32'h96, 8);
        send_frame(16, 16, 8, 8, 1'b0, 1'b0, 32'h96, 1'b0, 1'b0, 1'b0, -1);
        idle(30);
        check("post_reset_pending", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
